// File: rtl/wfrm_bank_loader.sv
// Purpose : loads one AXI-Stream waveform frame into the idle half of a double-buffered
//           sample memory and swaps banks once the frame is complete and playback is idle.
// Latency : memory writes appear 1 cycle after the accepted beat; commit takes 1 cycle.
// Backpr. : tready is 1 except while a finished frame waits for play_busy to drop.
// Ports   : axi_tclk/axi_treset   clock, synchronous active-high reset
//           s_axis_*              waveform stream; the first beat carries tdest and length (tuser)
//           mem_*                 registered write port, address = {bank, word index}
//           play_busy             playback owns the active bank, so a swap must wait
//           active_bank/wfrm_len/frame_cnt  committed state; wfrm_done/err_len/err_hdr  pulses
module wfrm_bank_loader #(
    parameter int         ADDR_W  = 12,
    parameter logic [3:0] DEST_ID = 4'b0010
) (
    input  logic              axi_tclk,
    input  logic              axi_treset,
    input  logic [31:0]       s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    input  logic [3:0]        s_axis_tkeep,
    input  logic [3:0]        s_axis_tdest,
    input  logic [3:0]        s_axis_tid,
    input  logic [31:0]       s_axis_tuser,
    output logic              s_axis_tready,
    output logic              mem_we,
    output logic [3:0]        mem_wbe,
    output logic [ADDR_W:0]   mem_waddr,
    output logic [31:0]       mem_wdata,
    input  logic              play_busy,
    output logic              active_bank,
    output logic [31:0]       wfrm_len,
    output logic              wfrm_done,
    output logic              err_len,
    output logic              err_hdr,
    output logic [15:0]       frame_cnt
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    localparam logic [32:0]     MAX_LEN = 33'd1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = 1;

    logic [1:0]        state;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   len;
    logic              accept;
    logic              hdr_bad;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W:0]   cnt_nxt;
    logic              unused_tid;

    assign unused_tid = ^s_axis_tid;

    assign s_axis_tready = (state != ST_COMMIT);
    assign accept        = s_axis_tvalid & s_axis_tready;
    // Length is compared in 33 bits so tuser values near 2^32 cannot wrap below the limit.
    assign hdr_bad = (s_axis_tdest != DEST_ID) || (s_axis_tuser == 32'd0) ||
                     ({1'b0, s_axis_tuser} > MAX_LEN);
    assign cnt_nxt = cnt + CNT_ONE;
    assign wr_en   = accept && (((state == ST_IDLE) && !hdr_bad) || (state == ST_LOAD));
    // In LOAD cnt < len <= 2^ADDR_W, so the low ADDR_W bits are the full word index.
    assign wr_idx  = (state == ST_IDLE) ? '0 : cnt[ADDR_W-1:0];

    // Write port: the bank being loaded is always the one playback is not reading.
    always_ff @(posedge axi_tclk) begin
        if (axi_treset) begin
            mem_we    <= 1'b0;
            mem_wbe   <= 4'd0;
            mem_waddr <= '0;
            mem_wdata <= 32'd0;
        end else begin
            mem_we <= wr_en;
            if (wr_en) begin
                mem_wbe   <= s_axis_tkeep;
                mem_waddr <= {~active_bank, wr_idx};
                mem_wdata <= s_axis_tdata;
            end
        end
    end

    always_ff @(posedge axi_tclk) begin
        if (axi_treset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            len         <= '0;
            active_bank <= 1'b0;
            wfrm_len    <= 32'd0;
            wfrm_done   <= 1'b0;
            err_len     <= 1'b0;
            err_hdr     <= 1'b0;
            frame_cnt   <= 16'd0;
        end else begin
            wfrm_done <= 1'b0;
            err_len   <= 1'b0;
            err_hdr   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (hdr_bad) begin
                            err_hdr <= 1'b1;
                            state   <= s_axis_tlast ? ST_IDLE : ST_DRAIN;
                        end else begin
                            len <= s_axis_tuser[ADDR_W:0];
                            cnt <= CNT_ONE;
                            if (s_axis_tlast) begin
                                if (s_axis_tuser == 32'd1) begin
                                    state <= ST_COMMIT;
                                end else begin
                                    err_len <= 1'b1;
                                    state   <= ST_IDLE;
                                end
                            end else if (s_axis_tuser == 32'd1) begin
                                // single-word waveform but the frame keeps going
                                err_len <= 1'b1;
                                state   <= ST_DRAIN;
                            end else begin
                                state <= ST_LOAD;
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        cnt <= cnt_nxt;
                        if (cnt_nxt == len) begin
                            if (s_axis_tlast) begin
                                state <= ST_COMMIT;
                            end else begin
                                err_len <= 1'b1;
                                state   <= ST_DRAIN;
                            end
                        end else if (s_axis_tlast) begin
                            err_len <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (accept && s_axis_tlast) begin
                        state <= ST_IDLE;
                    end
                end
                ST_COMMIT: begin
                    if (!play_busy) begin
                        active_bank <= ~active_bank;
                        wfrm_len    <= 32'(len);
                        wfrm_done   <= 1'b1;
                        frame_cnt   <= frame_cnt + 16'd1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wfrm_bank_loader.sv
// Bench for wfrm_bank_loader: directed frames, a frame-level reference model compared every
// cycle, and literal expectations for each scenario.
module tb_wfrm_bank_loader;

    logic        clk = 1'b0;
    logic        axi_treset = 1'b1;
    logic [31:0] s_axis_tdata = 32'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic [3:0]  s_axis_tkeep = 4'd0;
    logic [3:0]  s_axis_tdest = 4'd0;
    logic [3:0]  s_axis_tid = 4'h5;
    logic [31:0] s_axis_tuser = 32'd0;
    logic        s_axis_tready;
    logic        mem_we;
    logic [3:0]  mem_wbe;
    logic [12:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        play_busy = 1'b0;
    logic        active_bank;
    logic [31:0] wfrm_len;
    logic        wfrm_done;
    logic        err_len;
    logic        err_hdr;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    wfrm_bank_loader dut (
        .axi_tclk      (clk),
        .axi_treset    (axi_treset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tdest  (s_axis_tdest),
        .s_axis_tid    (s_axis_tid),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tready (s_axis_tready),
        .mem_we        (mem_we),
        .mem_wbe       (mem_wbe),
        .mem_waddr     (mem_waddr),
        .mem_wdata     (mem_wdata),
        .play_busy     (play_busy),
        .active_bank   (active_bank),
        .wfrm_len      (wfrm_len),
        .wfrm_done     (wfrm_done),
        .err_len       (err_len),
        .err_hdr       (err_hdr),
        .frame_cnt     (frame_cnt)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model (frame-level rules) ----------------
    bit          chk_en = 1'b0;
    bit          e_tready, e_active, e_done, e_errl, e_errh, e_we;
    logic [31:0] e_len, e_waddr, e_wdata, e_wbe;
    int          e_frame;
    int          k;          // beat index inside the current frame
    bit          hdr_ok;
    logic [32:0] flen;
    bit          pending;    // frame complete, waiting for the bank swap

    always @(posedge clk) begin
        e_done = 0; e_errl = 0; e_errh = 0; e_we = 0;
        if (axi_treset) begin
            e_tready = 1; e_active = 0; e_len = 0; e_frame = 0;
            k = 0; pending = 0; hdr_ok = 0; flen = 0; chk_en = 1;
        end else if (chk_en) begin
            if (pending) begin
                if (!play_busy) begin
                    e_active = !e_active; e_len = flen[31:0]; e_done = 1;
                    e_frame = (e_frame + 1) % 65536; pending = 0; e_tready = 1;
                end
            end else if (s_axis_tvalid) begin
                if (k == 0) begin
                    flen   = {1'b0, s_axis_tuser};
                    hdr_ok = (s_axis_tdest == 4'd2) && (flen != 0) && (flen <= 33'd4096);
                    if (!hdr_ok) e_errh = 1;
                end
                if (hdr_ok && (k < flen)) begin
                    e_we = 1;
                    e_waddr = (e_active ? 32'h0 : 32'h1000) + k;
                    e_wdata = s_axis_tdata;
                    e_wbe = {28'd0, s_axis_tkeep};
                    if (k == flen - 1) begin
                        if (s_axis_tlast) begin pending = 1; e_tready = 0; end
                        else e_errl = 1;
                    end else if (s_axis_tlast) begin
                        e_errl = 1;
                    end
                end
                k = s_axis_tlast ? 0 : k + 1;
            end
        end
    end

    // ---------------- per-cycle compare + observation counters ----------------
    int   n_wr = 0, n_done = 0, n_errl = 0, n_errh = 0;
    logic [12:0] wr_addr_q[$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tready", {31'd0, s_axis_tready}, {31'd0, e_tready});
            chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
            if (e_we) begin
                chk("mem_waddr", {19'd0, mem_waddr}, e_waddr);
                chk("mem_wdata", mem_wdata, e_wdata);
                chk("mem_wbe", {28'd0, mem_wbe}, e_wbe);
            end
            chk("active_bank", {31'd0, active_bank}, {31'd0, e_active});
            chk("wfrm_len", wfrm_len, e_len);
            chk("wfrm_done", {31'd0, wfrm_done}, {31'd0, e_done});
            chk("err_len", {31'd0, err_len}, {31'd0, e_errl});
            chk("err_hdr", {31'd0, err_hdr}, {31'd0, e_errh});
            chk("frame_cnt", {16'd0, frame_cnt}, e_frame);
        end
        if (mem_we === 1'b1) begin n_wr++; wr_addr_q.push_back(mem_waddr); end
        if (wfrm_done === 1'b1) n_done++;
        if (err_len === 1'b1) n_errl++;
        if (err_hdr === 1'b1) n_errh++;
    end

    // ---------------- stimulus helpers (called at posedge+2) ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        s_axis_tvalid = 0;
        axi_treset = 1;
        idle(2);
        axi_treset = 0;
    endtask

    task automatic beat(input logic [31:0] d, input logic [3:0] dest, input logic [31:0] user,
                        input logic last);
        bit hs, done;
        s_axis_tdata = d; s_axis_tdest = dest; s_axis_tuser = user; s_axis_tlast = last;
        s_axis_tkeep = ~d[3:0]; s_axis_tvalid = 1;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            hs = s_axis_tready;
            @(posedge clk);
            #2;
            if (hs) done = 1;
        end
        s_axis_tvalid = 0;
        if (!done) begin
            n_tot++;
            $display("FAIL handshake_timeout: got no tready expected tready within 100 cycles");
        end
    endtask

    task automatic frame(input logic [3:0] dest, input logic [31:0] user, input int n,
                         input logic [31:0] base);
        for (int i = 0; i < n; i++) beat(base + i, dest, user, i == n - 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        @(negedge clk);
        chk({tag, "_tready"}, {31'd0, s_axis_tready}, 32'd1);
        chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_waddr"}, {19'd0, mem_waddr}, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_wbe"}, {28'd0, mem_wbe}, 32'd0);
        chk({tag, "_active"}, {31'd0, active_bank}, 32'd0);
        chk({tag, "_len"}, wfrm_len, 32'd0);
        chk({tag, "_flags"}, {29'd0, wfrm_done, err_len, err_hdr}, 32'd0);
        chk({tag, "_fcnt"}, {16'd0, frame_cnt}, 32'd0);
        @(posedge clk);
        #2;
    endtask

    int w0, d0, l0, h0, f0, mk, busy_lo;
    logic a0;

    initial begin
        // reset and reset values
        do_reset();
        chk_reset_vals("rst");

        // 8-beat frame into bank 1, commit
        w0 = n_wr; mk = wr_addr_q.size();
        frame(4'd2, 32'd8, 8, 32'd0);
        idle(3);
        chk("t1_writes", n_wr - w0, 8);
        chk("t1_first_addr", {19'd0, wr_addr_q[mk]}, 32'h1000);
        chk("t1_last_addr", {19'd0, wr_addr_q[mk + 7]}, 32'h1007);
        chk("t1_done", n_done, 1);
        chk("t1_active", {31'd0, active_bank}, 32'd1);
        chk("t1_len", wfrm_len, 32'd8);
        chk("t1_fcnt", {16'd0, frame_cnt}, 32'd1);

        // commit held off by play_busy, then next frame lands in bank 0
        do_reset();
        play_busy = 1;
        d0 = n_done;
        frame(4'd2, 32'd4, 4, 32'h100);
        busy_lo = 0;
        repeat (10) begin
            @(negedge clk);
            if (s_axis_tready === 1'b0) busy_lo++;
        end
        play_busy = 0;
        chk("t2_busy_tready_low", busy_lo, 10);
        chk("t2_no_early_done", n_done - d0, 0);
        idle(2);
        chk("t2_done", n_done - d0, 1);
        chk("t2_active", {31'd0, active_bank}, 32'd1);
        mk = wr_addr_q.size();
        frame(4'd2, 32'd2, 2, 32'h200);
        idle(3);
        chk("t2_bank0_addr", {19'd0, wr_addr_q[mk]}, 32'h0000);

        // short frame: tuser 8, tlast on beat 5, then a normal frame
        a0 = active_bank; w0 = n_wr; l0 = n_errl; f0 = frame_cnt;
        frame(4'd2, 32'd8, 5, 32'h300);
        idle(2);
        chk("t3_writes", n_wr - w0, 5);
        chk("t3_errlen", n_errl - l0, 1);
        chk("t3_active", {31'd0, active_bank}, {31'd0, a0});
        frame(4'd2, 32'd3, 3, 32'h400);
        idle(3);
        chk("t3_next_commit", {16'd0, frame_cnt}, f0 + 1);

        // long frame: tuser 4, tlast on beat 7
        w0 = n_wr; l0 = n_errl;
        frame(4'd2, 32'd4, 7, 32'h500);
        idle(2);
        chk("t4_writes", n_wr - w0, 4);
        chk("t4_errlen", n_errl - l0, 1);

        // header faults: wrong dest, oversize length
        w0 = n_wr; h0 = n_errh;
        frame(4'd3, 32'd6, 6, 32'h600);
        frame(4'd2, 32'd4097, 6, 32'h700);
        idle(2);
        chk("t5_errhdr", n_errh - h0, 2);
        chk("t5_writes", n_wr - w0, 0);

        // length-1 boundaries: exact single beat commits, two-beat frame errors
        d0 = n_done; l0 = n_errl; w0 = n_wr;
        frame(4'd2, 32'd1, 1, 32'h800);
        idle(3);
        frame(4'd2, 32'd1, 2, 32'h900);
        idle(2);
        chk("t6_done", n_done - d0, 1);
        chk("t6_errlen", n_errl - l0, 1);
        chk("t6_writes", n_wr - w0, 2);
        chk("t6_len", wfrm_len, 32'd1);

        // reset after 3 of 8 beats; remaining 5 beats become a short frame
        for (int i = 0; i < 3; i++) beat(32'ha00 + i, 4'd2, 32'd8, 1'b0);
        do_reset();
        chk_reset_vals("t7_rst");
        w0 = n_wr; l0 = n_errl;
        for (int i = 3; i < 8; i++) beat(32'ha00 + i, 4'd2, 32'd8, i == 7);
        idle(2);
        chk("t7_writes", n_wr - w0, 5);
        chk("t7_errlen", n_errl - l0, 1);
        chk("t7_fcnt", {16'd0, frame_cnt}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/wfrm_bank_loader.md
WFRM_BANK_LOADER -- requirements
Module: wfrm_bank_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, giving log2 words per bank (4096).
REQ-002 SHALL have parameter DEST_ID, default 4'b0010, giving the tdest value accepted as waveform data.
REQ-003 SHALL have port axi_tclk, input, 1, the only clock; all logic rising-edge.
REQ-004 SHALL have port axi_treset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have slave stream ports s_axis_tdata in 32, s_axis_tvalid in 1, s_axis_tlast in 1, s_axis_tkeep in 4, s_axis_tdest in 4, s_axis_tid in 4 (ignored), s_axis_tuser in 32 (waveform length in words), s_axis_tready out 1.
REQ-006 SHALL have memory write ports mem_we out 1, mem_wbe out 4, mem_waddr out ADDR_W+1 ({bank, word index}), mem_wdata out 32.
REQ-007 SHALL have port play_busy, input, 1: playback is reading the active bank, so a bank swap is forbidden.
REQ-008 SHALL have outputs active_bank 1 (bank playback reads), wfrm_len 32 (length of the committed waveform), wfrm_done 1 (commit pulse), err_len 1 (length-mismatch pulse), err_hdr 1 (bad dest/length pulse), frame_cnt 16 (committed waveforms, wraps).

Function
REQ-009 SHALL implement states IDLE, LOAD, DRAIN and COMMIT.
REQ-010 SHALL drive s_axis_tready = 1 in IDLE, LOAD and DRAIN, and 0 in COMMIT; tready depends only on the registered state.
REQ-011 SHALL define an accepted beat as s_axis_tvalid & s_axis_tready.
REQ-012 SHALL use load bank = ~active_bank at all times.
REQ-013 SHALL classify a header fault on a beat accepted in IDLE when tdest != DEST_ID, tuser == 0, or tuser > 2^ADDR_W.
REQ-014 On a header fault, SHALL pulse err_hdr and write nothing; next state is DRAIN if tlast = 0, otherwise IDLE.
REQ-015 On a valid first beat, SHALL write it at word index 0, latch len = tuser and set cnt = 1.
REQ-016 After a valid first beat, next state SHALL be COMMIT if tlast & len==1; IDLE with an err_len pulse if tlast & len>1; LOAD if !tlast & len==1 is false; DRAIN with an err_len pulse if !tlast & len==1.
REQ-017 In LOAD, each accepted beat SHALL be written at word index cnt, and cnt SHALL increment; tuser and tdest are ignored after the first beat.
REQ-018 In LOAD, when cnt+1 == len on an accepted beat, next state SHALL be COMMIT if tlast, otherwise DRAIN with an err_len pulse (long frame).
REQ-019 In LOAD, tlast with cnt+1 < len SHALL pulse err_len and return to IDLE (short frame); that beat is still written.
REQ-020 In DRAIN, SHALL discard all beats with no write, and return to IDLE on the accepted tlast beat.
REQ-021 In COMMIT, SHALL wait while play_busy = 1.
REQ-022 In COMMIT with play_busy = 0, SHALL in one cycle toggle active_bank, set wfrm_len = len, pulse wfrm_done, increment frame_cnt (mod 2^16) and go to IDLE.
REQ-023 Writes SHALL be registered: mem_we/mem_waddr/mem_wdata/mem_wbe are valid the cycle after the accepted beat; mem_wbe = tkeep; mem_we is 1 for exactly one cycle per written beat.
REQ-024 All pulse outputs SHALL be registered and asserted for exactly one cycle.
REQ-025 A rejected or errored frame SHALL NOT change active_bank, wfrm_len or frame_cnt; partial data left in the load bank is don't-care.
REQ-026 cnt SHALL be ADDR_W+1 bits wide, so len = 2^ADDR_W is representable without wrap.

Reset
REQ-027 axi_treset SHALL force state IDLE; cnt, len, mem_we, mem_wbe, mem_waddr, mem_wdata, wfrm_done, err_len, err_hdr, frame_cnt, wfrm_len and active_bank to 0; s_axis_tready then reads 1.
REQ-028 A reset mid-LOAD or mid-COMMIT SHALL abort with no commit and no error pulse.

Verification
REQ-029 Sending 8 beats (data 0..7, tdest 2, tuser 8, tlast on beat 8) with play_busy 0 SHALL produce writes at addresses 0x1000..0x1007, then one wfrm_done pulse, active_bank 1, wfrm_len 8 and frame_cnt 1.
REQ-030 Sending a valid 4-beat frame while play_busy = 1 for 10 cycles SHALL hold tready at 0 for those cycles, with wfrm_done one cycle after play_busy falls; a second frame then loads into bank 0 (address 0x0000).
REQ-031 Sending tuser 8 with tlast on beat 5 SHALL give 5 writes, one err_len pulse, active_bank unchanged, and accept the next frame normally.
REQ-032 Sending tuser 4 with tlast on beat 7 SHALL give 4 writes, one err_len pulse, and beats 5-7 dropped with tready held at 1.
REQ-033 Sending tdest 3 or tuser 4097 on a 6-beat frame SHALL give one err_hdr pulse, zero writes, and the frame drained.
REQ-034 Asserting reset after 3 beats of an 8-beat frame SHALL return all outputs to reset values; the remaining beats are treated as new frames.
